stk_mem_init: RTL and testbench

Parametrised memory-initialisation engine for the stack (stk) pipeline. It replaces the fixed single-bank, zero-only initialiser. The engine walks a programmable line range across a programmable subset of banks, writing one of several data patterns. Writes leave through a valid/ready handshake so the engine can share the bank write port with functional traffic behind an arbiter.

---
 rtl/stk_pkg.sv | 22 ++
 rtl/stk_mem_init_bank_sel.sv | 36 +++
 rtl/stk_mem_init.sv | 169 ++++++++++++++++
 tb/tb_stk_mem_init.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stk_pkg.sv
// Shared types and default geometry for the stack pipeline.
// Holds the memory-initialiser pattern modes and FSM state encoding.
package stk_pkg;

  localparam int C_BANKS_N      = 4;
  localparam int C_BANK_LINES_N = 16;
  localparam int C_DATA_W       = 128;

  typedef enum logic [1:0] {
    MODE_ZERO     = 2'd0,
    MODE_FILL     = 2'd1,
    MODE_ADDR     = 2'd2,
    MODE_INV_ADDR = 2'd3
  } init_mode_t;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    DONE = 3'b100
  } init_state_t;

endpackage

// File: rtl/stk_mem_init_bank_sel.sv
// Combinational bank picker: lowest set mask bit, and the next set bit
// strictly above the current bank (with a flag saying one exists).
module stk_mem_init_bank_sel
  import stk_pkg::*;
#(
  parameter int BANKS_N = 4,
  parameter int BANK_W  = 2
) (
  input  logic [BANKS_N-1:0] mask,
  input  logic [BANK_W-1:0]  cur,
  output logic [BANK_W-1:0]  first_bank,
  output logic [BANK_W-1:0]  next_bank,
  output logic               has_next
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    first_bank = '0;
    next_bank  = '0;
    has_next   = 1'b0;
    for (int i = BANKS_N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_bank = BANK_W'(i);
        if (i > int'(cur)) begin
          next_bank = BANK_W'(i);
          has_next  = 1'b1;
        end else begin
          has_next = has_next;
        end
      end else begin
        first_bank = first_bank;
      end
    end
  end

endmodule

// File: rtl/stk_mem_init.sv
// Memory-initialisation engine: walks lines lo..hi across the selected banks
// (bank-major, ascending) and emits pattern writes over a valid/ready port.
module stk_mem_init
  import stk_pkg::*;
#(
  parameter int BANKS_N = C_BANKS_N,
  parameter int LINES_N = C_BANK_LINES_N,
  parameter int DATA_W  = C_DATA_W,
  parameter int ADDR_W  = $clog2(LINES_N),
  parameter int BANK_W  = (BANKS_N > 1) ? $clog2(BANKS_N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [ADDR_W-1:0]  i_lo,
  input  logic [ADDR_W-1:0]  i_hi,
  input  init_mode_t         i_mode,
  input  logic [DATA_W-1:0]  i_fill,
  input  logic [BANKS_N-1:0] i_bank_mask,
  output logic               o_init_wen_r,
  input  logic               i_init_wrdy,
  output logic [BANK_W-1:0]  o_init_bank_r,
  output logic [ADDR_W-1:0]  o_init_waddr_r,
  output logic [DATA_W-1:0]  o_init_wdata_r,
  output logic               o_busy_r,
  output logic               o_done_r
);

  init_state_t        state_r, state_s;
  logic [ADDR_W-1:0]  lo_r, lo_s, hi_r, hi_s, addr_r, addr_s;
  logic [BANK_W-1:0]  bank_r, bank_s;
  logic [BANKS_N-1:0] mask_r, mask_s, sel_mask_s;
  logic [DATA_W-1:0]  fill_r, fill_s;
  init_mode_t         mode_r, mode_s;
  logic [BANK_W-1:0]  first_bank_s, next_bank_s;
  logic               has_next_s;

  function automatic logic [DATA_W-1:0] pattern(input init_mode_t mode,
                                                input logic [DATA_W-1:0] fill,
                                                input logic [BANK_W-1:0] bank,
                                                input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] ba;
    logic [DATA_W-1:0] res;
    ba = '0;
    ba[BANK_W+ADDR_W-1:0] = {bank, addr};
    case (mode)
      MODE_ZERO:     res = '0;
      MODE_FILL:     res = fill;
      MODE_ADDR:     res = ba;
      MODE_INV_ADDR: res = ~ba;
      default:       res = '0;
    endcase
    return res;
  endfunction

  // In IDLE the picker sees the incoming mask so the first bank is ready at start.
  assign sel_mask_s = (state_r == IDLE) ? i_bank_mask : mask_r;

  stk_mem_init_bank_sel #(
    .BANKS_N (BANKS_N),
    .BANK_W  (BANK_W)
  ) u_bank_sel (
    .mask       (sel_mask_s),
    .cur        (bank_r),
    .first_bank (first_bank_s),
    .next_bank  (next_bank_s),
    .has_next   (has_next_s)
  );

  // Next-state, job latch and bank/addr advance.
  always_comb begin
    state_s = state_r;
    lo_s    = lo_r;
    hi_s    = hi_r;
    mode_s  = mode_r;
    fill_s  = fill_r;
    mask_s  = mask_r;
    bank_s  = bank_r;
    addr_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          lo_s   = i_lo;
          hi_s   = i_hi;
          mode_s = i_mode;
          fill_s = i_fill;
          mask_s = i_bank_mask;
          if ((i_bank_mask == '0) || (i_lo > i_hi)) begin
            state_s = DONE;
          end else begin
            state_s = BUSY;
            bank_s  = first_bank_s;
            addr_s  = i_lo;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (i_abort) begin
          state_s = IDLE;
        end else if (o_init_wen_r && i_init_wrdy) begin
          if (addr_r != hi_r) begin
            addr_s = addr_r + ADDR_W'(1);
          end else if (has_next_s) begin
            bank_s = next_bank_s;
            addr_s = lo_r;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, job fields and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lo_r    <= '0;
      hi_r    <= '0;
      mode_r  <= MODE_ZERO;
      fill_r  <= '0;
      mask_r  <= '0;
      bank_r  <= '0;
      addr_r  <= '0;
    end else begin
      state_r <= state_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      mode_r  <= mode_s;
      fill_r  <= fill_s;
      mask_r  <= mask_s;
      bank_r  <= bank_s;
      addr_r  <= addr_s;
    end
  end

  // Outputs are registered from the next state so they line up with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_init_wen_r   <= 1'b0;
      o_busy_r       <= 1'b0;
      o_done_r       <= 1'b0;
      o_init_bank_r  <= '0;
      o_init_waddr_r <= '0;
      o_init_wdata_r <= '0;
    end else begin
      o_init_wen_r <= (state_s == BUSY);
      o_busy_r     <= (state_s == BUSY);
      o_done_r     <= (state_s == DONE);
      if (state_s == BUSY) begin
        o_init_bank_r  <= bank_s;
        o_init_waddr_r <= addr_s;
        o_init_wdata_r <= pattern(mode_s, fill_s, bank_s, addr_s);
      end else begin
        o_init_bank_r  <= '0;
        o_init_waddr_r <= '0;
        o_init_wdata_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stk_mem_init.sv
// Directed self-checking bench for stk_mem_init (4 banks x 16 lines x 128 bits).
module tb_stk_mem_init;
  import stk_pkg::*;

  logic         clk, rst, i_start, i_abort, i_init_wrdy;
  logic [3:0]   i_lo, i_hi, i_bank_mask;
  init_mode_t   i_mode;
  logic [127:0] i_fill;
  logic         o_init_wen_r, o_busy_r, o_done_r;
  logic [1:0]   o_init_bank_r;
  logic [3:0]   o_init_waddr_r;
  logic [127:0] o_init_wdata_r;

  int errs = 0;
  int checks = 0;

  stk_mem_init #(.BANKS_N(4), .LINES_N(16), .DATA_W(128)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_lo(i_lo), .i_hi(i_hi), .i_mode(i_mode), .i_fill(i_fill),
    .i_bank_mask(i_bank_mask), .o_init_wen_r(o_init_wen_r),
    .i_init_wrdy(i_init_wrdy), .o_init_bank_r(o_init_bank_r),
    .o_init_waddr_r(o_init_waddr_r), .o_init_wdata_r(o_init_wdata_r),
    .o_busy_r(o_busy_r), .o_done_r(o_done_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input logic [3:0] mask, input logic [3:0] lo,
                         input logic [3:0] hi, input init_mode_t mode,
                         input logic [127:0] fill);
    i_bank_mask = mask; i_lo = lo; i_hi = hi; i_mode = mode; i_fill = fill;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_init_wrdy = 1'b1;
    set_job(4'b0000, 4'd0, 4'd0, MODE_ZERO, 128'd0);
    step(); step();
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !== 137'd0) begin
      errs++;
      $display("FAIL reset_outputs: wen=%b busy=%b done=%b bank=%0d addr=%0d data=%h, expected all 0",
               o_init_wen_r, o_busy_r, o_done_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b000) begin
      errs++;
      $display("FAIL idle_after_reset: wen/busy/done=%b expected 000", {o_init_wen_r, o_busy_r, o_done_r});
    end
  endtask

  task automatic test_zero_two_banks();
    logic [1:0]   eb;
    logic [3:0]   ea;
    set_job(4'b0101, 4'd0, 4'd15, MODE_ZERO, 128'd0);
    i_init_wrdy = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      eb = (k < 16) ? 2'd0 : 2'd2;
      ea = k[3:0];
      checks++;
      if ({o_init_wen_r, o_busy_r, o_done_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !==
          {1'b1, 1'b1, 1'b0, eb, ea, 128'd0}) begin
        errs++;
        $display("FAIL zero_beat[%0d]: wen=%b busy=%b done=%b bank=%0d addr=%0d data=%h, expected bank=%0d addr=%0d data=0",
                 k, o_init_wen_r, o_busy_r, o_done_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r, eb, ea);
      end
      step();
    end
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b001) begin
      errs++;
      $display("FAIL zero_done: wen/busy/done=%b expected 001", {o_init_wen_r, o_busy_r, o_done_r});
    end
    step();
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b000) begin
      errs++;
      $display("FAIL zero_done_once: wen/busy/done=%b expected 000", {o_init_wen_r, o_busy_r, o_done_r});
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]   pat;
    logic [3:0]   ea;
    logic [127:0] ed;
    int idx;
    pat = 4'b1001;
    idx = 0;
    set_job(4'b1000, 4'd3, 4'd5, MODE_ADDR, 128'd0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      ea = 4'(3 + idx);
      ed = 128'(3 * 16 + 3 + idx);
      checks++;
      if ({o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !== {1'b1, 2'd3, ea, ed}) begin
        errs++;
        $display("FAIL bp_beat[c=%0d]: wen=%b bank=%0d addr=%0d data=%h, expected bank=3 addr=%0d data=%h",
                 c, o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r, ea, ed);
      end
      i_init_wrdy = pat[c % 4];
      if (i_init_wrdy) idx++;
      step();
    end
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b001 || idx != 3) begin
      errs++;
      $display("FAIL bp_done: wen/busy/done=%b beats=%0d, expected 001 after 3 beats",
               {o_init_wen_r, o_busy_r, o_done_r}, idx);
    end
    i_init_wrdy = 1'b1;
    step();
  endtask

  task automatic test_empty();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) set_job(4'b1111, 4'd7, 4'd2, MODE_ZERO, 128'd0);
      else        set_job(4'b0000, 4'd0, 4'd15, MODE_ZERO, 128'd0);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      checks++;
      if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b001) begin
        errs++;
        $display("FAIL empty_done[%0d]: wen/busy/done=%b expected 001", t, {o_init_wen_r, o_busy_r, o_done_r});
      end
      step();
      checks++;
      if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b000) begin
        errs++;
        $display("FAIL empty_idle[%0d]: wen/busy/done=%b expected 000", t, {o_init_wen_r, o_busy_r, o_done_r});
      end
    end
  endtask

  task automatic test_abort();
    logic [127:0] fill;
    logic         seen_done;
    logic [1:0]   eb;
    logic [3:0]   ea;
    fill = {16{8'hA5}};
    set_job(4'b0011, 4'd0, 4'd15, MODE_FILL, fill);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ea = k[3:0];
      checks++;
      if ({o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !== {1'b1, 2'd0, ea, fill}) begin
        errs++;
        $display("FAIL abort_beat[%0d]: wen=%b bank=%0d addr=%0d data=%h, expected bank=0 addr=%0d fill",
                 k, o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r, ea);
      end
      if (k == 5) i_abort = 1'b1;
      step();
    end
    i_abort = 1'b0;
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b000) begin
      errs++;
      $display("FAIL abort_stop: wen/busy/done=%b expected 000", {o_init_wen_r, o_busy_r, o_done_r});
    end
    seen_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      seen_done = seen_done | o_done_r | o_init_wen_r;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errs++;
      $display("FAIL abort_no_done: activity after abort=%b expected 0", seen_done);
    end
    set_job(4'b0011, 4'd0, 4'd1, MODE_FILL, fill);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      eb = 2'(k / 2);
      ea = 4'(k % 2);
      checks++;
      if ({o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !== {1'b1, eb, ea, fill}) begin
        errs++;
        $display("FAIL restart_beat[%0d]: wen=%b bank=%0d addr=%0d, expected bank=%0d addr=%0d",
                 k, o_init_wen_r, o_init_bank_r, o_init_waddr_r, eb, ea);
      end
      step();
    end
    checks++;
    if (o_done_r !== 1'b1) begin
      errs++;
      $display("FAIL restart_done: done=%b expected 1", o_done_r);
    end
    step();
  endtask

  task automatic test_rst_mid();
    set_job(4'b0001, 4'd0, 4'd15, MODE_ADDR, 128'd0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step(); step();
    checks++;
    if ({o_init_wen_r, o_init_waddr_r} !== {1'b1, 4'd3}) begin
      errs++;
      $display("FAIL rst_pre: wen=%b addr=%0d expected wen=1 addr=3", o_init_wen_r, o_init_waddr_r);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !== 137'd0) begin
      errs++;
      $display("FAIL rst_mid: wen=%b busy=%b done=%b bank=%0d addr=%0d data=%h, expected all 0",
               o_init_wen_r, o_busy_r, o_done_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b000) begin
      errs++;
      $display("FAIL rst_idle: wen/busy/done=%b expected 000", {o_init_wen_r, o_busy_r, o_done_r});
    end
  endtask

  task automatic test_start_ignored();
    logic [1:0]   eb;
    logic [3:0]   ea;
    logic [127:0] ed;
    set_job(4'b0110, 4'd1, 4'd2, MODE_ADDR, 128'd0);
    i_start = 1'b1;
    step();
    set_job(4'b1111, 4'd0, 4'd3, MODE_ZERO, 128'd0);
    for (int k = 0; k < 4; k++) begin
      eb = 2'(1 + k / 2);
      ea = 4'(1 + k % 2);
      ed = 128'((1 + k / 2) * 16 + 1 + k % 2);
      checks++;
      if ({o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !== {1'b1, eb, ea, ed}) begin
        errs++;
        $display("FAIL start_busy_beat[%0d]: wen=%b bank=%0d addr=%0d data=%h, expected bank=%0d addr=%0d data=%h",
                 k, o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r, eb, ea, ed);
      end
      step();
    end
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b001) begin
      errs++;
      $display("FAIL start_busy_done: wen/busy/done=%b expected 001", {o_init_wen_r, o_busy_r, o_done_r});
    end
    step();
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b000) begin
      errs++;
      $display("FAIL start_in_done: wen/busy/done=%b expected 000", {o_init_wen_r, o_busy_r, o_done_r});
    end
    i_start = 1'b0;
    step();
  endtask

  task automatic test_top_addr();
    logic [1:0]   eb;
    logic [127:0] ed;
    set_job(4'b1111, 4'd15, 4'd15, MODE_INV_ADDR, 128'd0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      eb = 2'(b);
      ed = ~(128'(b * 16 + 15));
      checks++;
      if ({o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r} !== {1'b1, eb, 4'd15, ed}) begin
        errs++;
        $display("FAIL top_beat[%0d]: wen=%b bank=%0d addr=%0d data=%h, expected bank=%0d addr=15 data=%h",
                 b, o_init_wen_r, o_init_bank_r, o_init_waddr_r, o_init_wdata_r, eb, ed);
      end
      step();
    end
    checks++;
    if ({o_init_wen_r, o_busy_r, o_done_r} !== 3'b001) begin
      errs++;
      $display("FAIL top_done: wen/busy/done=%b expected 001", {o_init_wen_r, o_busy_r, o_done_r});
    end
    step();
  endtask

  initial begin
    test_reset();
    test_zero_two_banks();
    test_backpressure();
    test_empty();
    test_abort();
    test_rst_mid();
    test_start_ignored();
    test_top_addr();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
